// File: rtl/fwd_pkg.sv
// Shared types for the operand-bypass / scoreboard block.
package fwd_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREG  = 32;
  localparam int REG_IDX_W = $clog2(DEF_NREG);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One pipeline stage's view of its register-writing result.
  typedef struct packed {
    logic                valid;
    logic                ready;
    reg_idx_t            rd;
    logic [DEF_XLEN-1:0] data;
  } byp_entry_t;

endpackage

// File: rtl/fwd_sel.sv
// Resolves one source operand from bypass stages, the long-op completion
// port or the register file, and reports whether that source must wait.
module fwd_sel #(
  parameter int XLEN = 64,
  parameter int IDXW = 5,
  parameter int NBYP = 3
) (
  input  logic [IDXW-1:0]            rs,
  input  logic                       use_src,
  input  logic [NBYP-1:0]            byp_valid,
  input  logic [NBYP-1:0]            byp_ready,
  input  logic [NBYP-1:0][IDXW-1:0]  byp_rd,
  input  logic [NBYP-1:0][XLEN-1:0]  byp_data,
  input  logic                       lo_done,
  input  logic [IDXW-1:0]            lo_rd,
  input  logic [XLEN-1:0]            lo_data,
  input  logic [XLEN-1:0]            rf_data,
  input  logic                       sb_pending,
  output logic [XLEN-1:0]            data,
  output logic                       hazard
);

  logic            rs_nz;
  logic            hit;
  logic            hit_ready;
  logic [XLEN-1:0] hit_data;
  logic            lo_hit;

  assign rs_nz  = (rs != '0);
  assign lo_hit = lo_done && (lo_rd == rs) && rs_nz;

  // Find the youngest matching bypass stage; older matches are shadowed.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    hit       = 1'b0;
    hit_ready = 1'b0;
    hit_data  = '0;
    for (int i = 0; i < NBYP; i++) begin
      if (!hit && rs_nz && byp_valid[i] && (byp_rd[i] == rs)) begin
        hit       = 1'b1;
        hit_ready = byp_ready[i];
        hit_data  = byp_data[i];
      end
    end
  end

  // Priority mux for the operand value and the source hazard.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    if (!rs_nz) begin
      data = '0;
    end else if (hit) begin
      data   = hit_data;
      hazard = use_src && !hit_ready;
    end else if (lo_hit) begin
      data = lo_data;
    end else begin
      hazard = use_src && sb_pending;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand bypass with long-latency scoreboard, stall generation and a
// saturating stall-cycle counter.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NBYP = 3,
  parameter int CNTW = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_valid,
  input  logic [$clog2(NREG)-1:0]      id_rs1,
  input  logic [$clog2(NREG)-1:0]      id_rs2,
  input  logic [$clog2(NREG)-1:0]      id_rd,
  input  logic                         id_long,
  input  logic                         with_imm,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              rf_data1,
  input  logic [XLEN-1:0]              rf_data2,
  input  logic [NBYP-1:0]              byp_valid,
  input  logic [NBYP-1:0]              byp_ready,
  input  logic [NBYP*$clog2(NREG)-1:0] byp_rd,
  input  logic [NBYP*XLEN-1:0]         byp_data,
  input  logic                         lo_done,
  input  logic [$clog2(NREG)-1:0]      lo_rd,
  input  logic [XLEN-1:0]              lo_data,
  input  logic                         flush,
  output logic [XLEN-1:0]              out1,
  output logic [XLEN-1:0]              out2,
  output logic                         stall,
  output logic [NREG-1:0]              sb_busy,
  output logic [CNTW-1:0]              stall_cnt
);

  localparam int IDXW = $clog2(NREG);

  logic [NBYP-1:0][IDXW-1:0] byp_rd_a;
  logic [NBYP-1:0][XLEN-1:0] byp_data_a;
  logic [NREG-1:0]           sb_busy_d, sb_busy_q;
  logic [CNTW-1:0]           stall_cnt_d, stall_cnt_q;
  logic [XLEN-1:0]           sel2_data;
  logic                      haz1, haz2, hazard_waw, lo_hits_rd;

  assign byp_rd_a   = byp_rd;
  assign byp_data_a = byp_data;

  fwd_sel #(.XLEN(XLEN), .IDXW(IDXW), .NBYP(NBYP)) u_sel1 (
    .rs         (id_rs1),
    .use_src    (1'b1),
    .byp_valid  (byp_valid),
    .byp_ready  (byp_ready),
    .byp_rd     (byp_rd_a),
    .byp_data   (byp_data_a),
    .lo_done    (lo_done),
    .lo_rd      (lo_rd),
    .lo_data    (lo_data),
    .rf_data    (rf_data1),
    .sb_pending (sb_busy_q[id_rs1]),
    .data       (out1),
    .hazard     (haz1)
  );

  fwd_sel #(.XLEN(XLEN), .IDXW(IDXW), .NBYP(NBYP)) u_sel2 (
    .rs         (id_rs2),
    .use_src    (!with_imm),
    .byp_valid  (byp_valid),
    .byp_ready  (byp_ready),
    .byp_rd     (byp_rd_a),
    .byp_data   (byp_data_a),
    .lo_done    (lo_done),
    .lo_rd      (lo_rd),
    .lo_data    (lo_data),
    .rf_data    (rf_data2),
    .sb_pending (sb_busy_q[id_rs2]),
    .data       (sel2_data),
    .hazard     (haz2)
  );

  assign out2 = with_imm ? imm : sel2_data;

  // A long op completing into the same register this cycle resolves the WAW.
  assign lo_hits_rd = lo_done && (lo_rd == id_rd);
  assign hazard_waw = id_long && (id_rd != '0) && sb_busy_q[id_rd] && !lo_hits_rd;
  assign stall      = id_valid && !flush && (haz1 || haz2 || hazard_waw);

  // Scoreboard next state: completion clears first, issue sets last so it wins.
  always_comb begin
    sb_busy_d = sb_busy_q;
    if (lo_done) begin
      sb_busy_d[lo_rd] = 1'b0;
    end
    if (id_valid && id_long && !stall && !flush && (id_rd != '0)) begin
      sb_busy_d[id_rd] = 1'b1;
    end
    sb_busy_d[0] = 1'b0;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      sb_busy_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_busy_q   <= sb_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb_busy   = sb_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard-style bench: the driver predicts each cycle's outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int XLEN = DEF_XLEN;
  localparam int NREG = DEF_NREG;
  localparam int NBYP = 3;
  localparam int CNTW = 6;
  localparam int IW   = $clog2(NREG);
  localparam longint CNT_MAX = (64'd1 << CNTW) - 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 id_valid;
  logic [IW-1:0]        id_rs1, id_rs2, id_rd;
  logic                 id_long, with_imm;
  logic [XLEN-1:0]      imm, rf_data1, rf_data2;
  logic [NBYP-1:0]      byp_valid, byp_ready;
  logic [NBYP*IW-1:0]   byp_rd;
  logic [NBYP*XLEN-1:0] byp_data;
  logic                 lo_done;
  logic [IW-1:0]        lo_rd;
  logic [XLEN-1:0]      lo_data;
  logic                 flush;
  logic [XLEN-1:0]      out1, out2;
  logic                 stall;
  logic [NREG-1:0]      sb_busy;
  logic [CNTW-1:0]      stall_cnt;

  fwd_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NBYP(NBYP), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_long(id_long), .with_imm(with_imm), .imm(imm),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .byp_valid(byp_valid),
    .byp_ready(byp_ready), .byp_rd(byp_rd), .byp_data(byp_data),
    .lo_done(lo_done), .lo_rd(lo_rd), .lo_data(lo_data), .flush(flush),
    .out1(out1), .out2(out2), .stall(stall), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] o1;
    logic [XLEN-1:0] o2;
    logic            st;
    logic [NREG-1:0] busy;
    logic [63:0]     cnt;
  } exp_t;

  exp_t       exp_q[$];
  byp_entry_t ent[NBYP];
  bit [NREG-1:0] m_busy = '0;
  longint     m_cnt = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".out1"}, out1, e.o1);
      check({e.tag, ".out2"}, out2, e.o2);
      check({e.tag, ".stall"}, {63'd0, stall}, {63'd0, e.st});
      check({e.tag, ".sb_busy"}, {32'd0, sb_busy}, {32'd0, e.busy});
      check({e.tag, ".stall_cnt"}, {58'd0, stall_cnt}, e.cnt);
    end
  end

  // Reference resolution: rs0 is zero, then youngest stage, then long-op port, then RF.
  function automatic void resolve(input logic [IW-1:0] rs, input logic [XLEN-1:0] rf,
                                  output logic [XLEN-1:0] val, output bit haz);
    val = rf;
    haz = 0;
    if (rs == 0) begin
      val = '0;
      return;
    end
    for (int i = 0; i < NBYP; i++) begin
      if (ent[i].valid && ent[i].rd == rs) begin
        val = ent[i].data;
        haz = !ent[i].ready;
        return;
      end
    end
    if (lo_done && lo_rd == rs) begin
      val = lo_data;
      return;
    end
    haz = m_busy[rs];
  endfunction

  // Drive the current stimulus for one cycle, predict, enqueue, advance model.
  task automatic step(input string tag);
    exp_t e;
    logic [XLEN-1:0] v1, v2;
    bit h1, h2, waw, st;
    for (int i = 0; i < NBYP; i++) begin
      byp_valid[i]             = ent[i].valid;
      byp_ready[i]             = ent[i].ready;
      byp_rd[i*IW +: IW]       = ent[i].rd;
      byp_data[i*XLEN +: XLEN] = ent[i].data;
    end
    resolve(id_rs1, rf_data1, v1, h1);
    resolve(id_rs2, rf_data2, v2, h2);
    if (with_imm) begin
      v2 = imm;
      h2 = 0;
    end
    waw = id_long && id_rd != 0 && m_busy[id_rd] && !(lo_done && lo_rd == id_rd);
    st  = id_valid && !flush && (h1 || h2 || waw);
    e.tag  = tag;
    e.o1   = v1;
    e.o2   = v2;
    e.st   = st;
    e.busy = m_busy;
    e.cnt  = 64'(m_cnt);
    exp_q.push_back(e);
    if (rst) begin
      m_busy = '0;
      m_cnt  = 0;
    end else begin
      if (lo_done) m_busy[lo_rd] = 1'b0;
      if (id_valid && id_long && !st && !flush && id_rd != 0) m_busy[id_rd] = 1'b1;
      m_busy[0] = 1'b0;
      if (st && m_cnt < CNT_MAX) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_ent(input int i, input bit v, input bit r, input int rd, input logic [XLEN-1:0] d);
    ent[i].valid = v;
    ent[i].ready = r;
    ent[i].rd    = reg_idx_t'(rd);
    ent[i].data  = d;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_long = 0;
    with_imm = 0; imm = 0; lo_done = 0; lo_rd = 0; lo_data = 0; flush = 0;
    rf_data1 = {$urandom, $urandom};
    rf_data2 = {$urandom, $urandom};
    for (int i = 0; i < NBYP; i++) set_ent(i, 0, 0, 0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    idle();
    for (int i = 0; i < NBYP; i++) begin
      byp_valid[i] = 0; byp_ready[i] = 0;
    end
    byp_rd = '0; byp_data = '0;
    @(posedge clk); #1;
    step("reset");
    rst = 0;

    // Youngest of two matching stages wins.
    idle(); id_valid = 1; id_rs1 = 5;
    set_ent(0, 1, 1, 5, 64'hA); set_ent(2, 1, 1, 5, 64'hB);
    step("youngest");

    // Immediate bypasses an unready stage; without it the source stalls.
    idle(); id_valid = 1; id_rs2 = 7; with_imm = 1; imm = 64'h10;
    set_ent(1, 1, 0, 7, 64'h77);
    step("imm_noload");
    with_imm = 0;
    repeat (3) step("load_use");

    // Long op issue, dependent stall, completion forwarding.
    idle(); id_valid = 1; id_long = 1; id_rd = 9;
    step("long_issue");
    idle(); id_valid = 1; id_rs1 = 9;
    step("sb_stall");
    lo_done = 1; lo_rd = 9; lo_data = 64'h55;
    step("lo_forward");
    idle();
    step("sb_cleared");

    // WAW hazard and set-wins on simultaneous clear.
    idle(); id_valid = 1; id_long = 1; id_rd = 3;
    step("long3_issue");
    step("waw_stall");
    lo_done = 1; lo_rd = 3; lo_data = 64'h33;
    step("waw_resolved");
    idle();
    step("set_wins");

    // r0 never forwards; flush suppresses stall and issue.
    idle(); id_valid = 1; id_rs1 = 0; set_ent(0, 1, 1, 0, 64'hFF);
    step("rs0");
    idle(); id_valid = 1; id_rs1 = 3; id_long = 1; id_rd = 4; flush = 1;
    step("flush");
    idle();
    step("flush_after");
    lo_done = 1; lo_rd = 3;
    step("clear3");
    lo_done = 1; lo_rd = 12;
    step("stray_lo");

    // Randomised traffic over a small register window to provoke matches.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs1   = IW'($urandom_range(0, 7));
      id_rs2   = IW'($urandom_range(0, 7));
      id_rd    = IW'($urandom_range(0, 7));
      id_long  = ($urandom_range(0, 3) == 0);
      with_imm = ($urandom_range(0, 1) == 1);
      imm      = {$urandom, $urandom};
      rf_data1 = {$urandom, $urandom};
      rf_data2 = {$urandom, $urandom};
      for (int i = 0; i < NBYP; i++)
        set_ent(i, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                $urandom_range(0, 7), {$urandom, $urandom});
      lo_done  = ($urandom_range(0, 2) == 0);
      lo_rd    = IW'($urandom_range(0, 7));
      lo_data  = {$urandom, $urandom};
      flush    = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    // Counter saturation, then reset in the middle of a stall.
    idle(); rst = 1;
    step("sat_reset");
    rst = 0; id_valid = 1; id_long = 1; id_rd = 6;
    step("sat_long6");
    idle(); id_valid = 1; id_rs1 = 5; set_ent(0, 1, 0, 5, 64'h1);
    repeat (70) step("saturate");
    rst = 1;
    step("rst_mid");
    rst = 0;
    idle();
    step("post_rst");
    lo_done = 1; lo_rd = 6;
    step("late_lo");
    idle();
    step("final");

    repeat (2) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-bypass unit with hazard tracking, placed in the ID stage ahead of the ALU operand muxes.
- Selects each source operand from N ordered bypass stages, a long-latency completion port, an immediate, or the register file.
- Keeps a per-register scoreboard for in-flight long-latency ops (mul/div/AMO) and raises stall on load-use, scoreboard and WAW hazards.
- Counts stall cycles for performance monitoring.

Parameters:
- XLEN, 64, operand/data width
- NREG, 32, architectural register count; register 0 is hard-wired zero
- NBYP, 3, number of bypass stages; index 0 is youngest (EX), NBYP-1 is oldest (WB)
- CNTW, 32, stall-counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  instruction in ID
- id_rs1, id_rs2  in  $clog2(NREG) each  source register indices
- id_rd  in  $clog2(NREG)  destination register index
- id_long  in  1  ID instruction is a long-latency op
- with_imm  in  1  operand 2 takes the immediate
- imm  in  XLEN  immediate value
- rf_data1, rf_data2  in  XLEN each  register-file read data
- byp_valid  in  NBYP  stage holds a register-writing instruction
- byp_ready  in  NBYP  stage data is available (0 = load not yet returned)
- byp_rd  in  NBYP*$clog2(NREG)  packed destination indices
- byp_data  in  NBYP*XLEN  packed result data
- lo_done  in  1  long op completes this cycle
- lo_rd  in  $clog2(NREG)  completing destination register
- lo_data  in  XLEN  completing result
- flush  in  1  kill the ID instruction
- out1, out2  out  XLEN each  resolved operands
- stall  out  1  hold ID and earlier stages
- sb_busy  out  NREG  scoreboard pending bits
- stall_cnt  out  CNTW  saturating count of stall cycles

Behaviour:
- Reset: sb_busy=0, stall_cnt=0. out1, out2 and stall are combinational and therefore valid in the reset cycle.
- Operand resolution for out1 (out2 is identical, except with_imm=1 selects imm first):
  1. rs==0 → 0.
  2. Youngest matching bypass stage i (byp_valid[i] && byp_rd[i]==rs) → byp_data[i]. Older matching stages are ignored even if ready.
  3. lo_done && lo_rd==rs → lo_data.
  4. Otherwise → rf_data.
- A bypass entry with byp_rd==0 never matches.
- Source use: rs1 is always a source. rs2 is a source only when with_imm==0.
- hazard_src: for a used source rs≠0, either of:
  - the youngest matching stage has byp_ready==0;
  - no stage matches, sb_busy[rs]==1 and !(lo_done && lo_rd==rs).
- hazard_waw: id_long && id_rd≠0 && sb_busy[id_rd] && !(lo_done && lo_rd==id_rd).
- stall = id_valid && !flush && (hazard_src || hazard_waw).
- Scoreboard, registered each cycle in this order:
  - Clear bit lo_rd when lo_done.
  - Then set bit id_rd when id_valid && id_long && !stall && !flush && id_rd≠0.
  - If set and clear hit the same register in one cycle, set wins.
  - Bit 0 is always 0.
- lo_done for a register whose bit is clear is ignored; no error is raised.
- flush: suppresses stall and the scoreboard set. It does not clear pending bits, because in-flight long ops always complete.
- stall_cnt: increments on every cycle with stall=1 and saturates at all-ones.
- rst asserted mid-operation: bits and counter return to 0 on the next edge. Any later lo_done is ignored.
- Latency: operands and stall are 0-cycle combinational. Scoreboard updates are visible the cycle after the edge.

Decomposition:
- Shared package fwd_pkg holds: REG_IDX_W, the register-index typedef, and the bypass-entry struct {valid, ready, rd, data} used by the pipeline stages.
- Sub-module fwd_sel, instantiated twice (once per operand), takes (rs, use, entries, lo port, rf_data) and returns (data, hazard).
- The top level holds the scoreboard, the WAW check, the stall logic and the counter.

Test Plan:
- rs1=5; byp0 {v,r,rd=5,data=0xA}; byp2 {v,r,rd=5,data=0xB} → out1=0xA, stall=0.
- rs2=7, with_imm=1, imm=0x10; byp1 {v,ready=0,rd=7} → out2=0x10, stall=0. Same stimulus with with_imm=0 → stall=1, stall_cnt increments by 1 per cycle.
- Issue id_long with rd=9 → sb_busy[9]=1 next cycle. Next instruction has rs1=9 → stall=1. Assert lo_done with lo_rd=9 and lo_data=0x55 → out1=0x55 and stall=0 that same cycle; sb_busy[9]=0 afterwards.
- sb_busy[3]=1; id_long issues with rd=3 and no lo_done → stall=1 (WAW). Same cycle with lo_done, lo_rd=3 → stall=0 and sb_busy[3] stays 1 (set wins).
- rs1=0 with byp0 {v,r,rd=0,data=0xFF} → out1=0, stall=0. flush=1 during a stall condition → stall=0 and sb_busy unchanged.
- Preload stall_cnt near all-ones, hold a stall → counter saturates at all-ones. Assert rst mid-stall → sb_busy=0 and stall_cnt=0 next cycle.
